// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: two-entry skid buffer with registered in_ready (SKID=1),
// or a single register with combinational in_ready (SKID=0). Tracks back-pressure cycles.
module pipe_stage_skid #(
  parameter int DATA_W         = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   main_r, main_s;
  logic [DATA_W-1:0]   skid_r, skid_s;
  logic                in_ready_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                out_valid_s;
  logic                in_xfer_s;
  logic                out_xfer_s;

  assign out_valid_s = (state_r != ST_EMPTY);
  // SKID=1 keeps out_ready off the in_ready path entirely.
  assign in_ready    = (SKID != 0) ? in_ready_r : (out_ready | ~out_valid_s);
  assign in_xfer_s   = in_valid & in_ready;
  assign out_xfer_s  = out_valid_s & out_ready;
  assign out_valid   = out_valid_s;
  assign out_data    = main_r;
  assign stall_cnt   = stall_cnt_r;

  // Next-state and payload steering.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_s = DATA_ZERO;
        skid_s = DATA_ZERO;
      end else begin
        main_s = main_r;
        skid_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_s = in_data;
          end else if (in_xfer_s) begin
            // Unreachable with SKID=0: in_ready implies out_ready while valid.
            if (SKID != 0) begin
              state_s = ST_FULL;
              skid_s  = in_data;
            end else begin
              main_s = in_data;
            end
          end else if (out_xfer_s) begin
            state_s = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
              main_s = DATA_ZERO;
            end else begin
              main_s = main_r;
            end
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
            if (CLEAR_ON_FLUSH != 0) begin
              skid_s = DATA_ZERO;
            end else begin
              skid_s = skid_r;
            end
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          main_s  = DATA_ZERO;
          skid_s  = DATA_ZERO;
        end
      endcase
    end
  end

  // Occupancy decode from the state register.
  always_comb begin
    occupancy = 2'd0;
    case (state_r)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // State, payload, registered in_ready and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= DATA_ZERO;
      skid_r      <= DATA_ZERO;
      in_ready_r  <= 1'b1;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      main_r     <= main_s;
      skid_r     <= skid_s;
      in_ready_r <= (state_s != ST_FULL);
      if (!flush && out_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations checked every cycle against a
// FIFO-level reference model, plus directed scenarios and randomized traffic.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic [2:0]  flush;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] in_data   [3];
  logic [31:0] out_data  [3];
  logic [1:0]  occupancy [3];
  logic [15:0] stall_a, stall_b;
  logic [1:0]  stall_c;
  logic [31:0] stall_v   [3];

  assign stall_v[0] = {16'd0, stall_a};
  assign stall_v[1] = {16'd0, stall_b};
  assign stall_v[2] = {30'd0, stall_c};

  // Instance configuration as seen by the model.
  int skid_p [3] = '{1, 0, 1};
  int clr_p  [3] = '{1, 1, 0};
  int cmax   [3] = '{65535, 65535, 3};

  // Reference model: ordered list of held entries and a stall count.
  logic [31:0] mmem  [3][2];
  int          msize [3];
  int          mcnt  [3];
  bit          armed;
  int          errors;
  int          checks;

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0]), .stall_cnt(stall_a));

  pipe_stage_skid #(.DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1]), .stall_cnt(stall_b));

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(0), .CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .occupancy(occupancy[2]), .stall_cnt(stall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] d,
                       input logic ordy, input logic f);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = ordy;
    flush[k]     = f;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // One clock: compare all outputs before the edge, then advance the model.
  task automatic tick(input logic rst);
    logic exp_rdy;
    bit   in_x, out_x;
    reset = rst;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_rdy = (skid_p[k] != 0) ? (msize[k] < 2) : (out_ready[k] || msize[k] == 0);
      if (armed) begin
        check($sformatf("rdy%0d", k), 32'(in_ready[k]), 32'(exp_rdy));
        check($sformatf("vld%0d", k), 32'(out_valid[k]), 32'(msize[k] != 0));
        check($sformatf("occ%0d", k), 32'(occupancy[k]), 32'(msize[k]));
        check($sformatf("cnt%0d", k), stall_v[k], 32'(mcnt[k]));
        if (msize[k] > 0) check($sformatf("dat%0d", k), out_data[k], mmem[k][0]);
        else if (clr_p[k] != 0) check($sformatf("zero%0d", k), out_data[k], 32'd0);
      end
      if (rst) begin
        msize[k] = 0;
        mcnt[k]  = 0;
      end else if (flush[k]) begin
        msize[k] = 0;
      end else begin
        in_x  = in_valid[k] && exp_rdy;
        out_x = (msize[k] > 0) && out_ready[k];
        if (msize[k] > 0 && !out_ready[k] && mcnt[k] < cmax[k]) mcnt[k]++;
        if (out_x) begin
          mmem[k][0] = mmem[k][1];
          msize[k]--;
        end
        if (in_x) begin
          mmem[k][msize[k]] = in_data[k];
          msize[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) armed = 1'b1;
  endtask

  int stall_exp [6] = '{1, 2, 3, 3, 3, 3};
  int burst;

  initial begin
    errors = 0;
    checks = 0;
    armed  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      msize[k] = 0;
      mcnt[k]  = 0;
    end
    idle_all();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1);

    // Streaming at full rate through the skid stage.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 32'h11 + 32'(i), 1'b1, 1'b0);
      tick(1'b0);
    end
    idle_all();
    tick(1'b0);
    tick(1'b0);
    check("stream_cnt", stall_v[0], 32'd0);

    // Back-pressure fills both entries; third offer waits upstream.
    drive(0, 1'b1, 32'h0A, 1'b0, 1'b0); tick(1'b0);
    drive(0, 1'b1, 32'h0B, 1'b0, 1'b0); tick(1'b0);
    check("full_occ", 32'(occupancy[0]), 32'd2);
    check("full_rdy", 32'(in_ready[0]), 32'd0);
    drive(0, 1'b1, 32'h0C, 1'b0, 1'b0); tick(1'b0);
    drive(0, 1'b1, 32'h0C, 1'b1, 1'b0); tick(1'b0);
    tick(1'b0);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0); tick(1'b0);
    tick(1'b0);

    // Flush while FULL beats simultaneous input and output transfers.
    drive(0, 1'b1, 32'h31, 1'b0, 1'b0); tick(1'b0);
    drive(0, 1'b1, 32'h32, 1'b0, 1'b0); tick(1'b0);
    drive(0, 1'b1, 32'h0D, 1'b1, 1'b1); tick(1'b0);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_occ", 32'(occupancy[0]), 32'd0);
    check("flush_vld", 32'(out_valid[0]), 32'd0);
    check("flush_dat", out_data[0], 32'd0);
    tick(1'b0);

    // Single-register mode: in_ready tracks out_ready in the same cycle.
    drive(1, 1'b1, 32'h05, 1'b0, 1'b0); tick(1'b0);
    drive(1, 1'b1, 32'h06, 1'b0, 1'b0); tick(1'b0);
    drive(1, 1'b1, 32'h06, 1'b1, 1'b0); tick(1'b0);
    drive(1, 1'b1, 32'h07, 1'b0, 1'b0); tick(1'b0);
    drive(1, 1'b1, 32'h07, 1'b1, 1'b0); tick(1'b0);
    drive(1, 1'b0, 32'h0, 1'b1, 1'b0); tick(1'b0);
    tick(1'b0);

    // Stall counter saturation with a 2-bit counter.
    drive(2, 1'b1, 32'h77, 1'b0, 1'b0); tick(1'b0);
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      check($sformatf("sat%0d", i), stall_v[2], 32'(stall_exp[i]));
    end
    idle_all();
    tick(1'b0);

    // Reset while FULL discards everything.
    drive(0, 1'b1, 32'h21, 1'b0, 1'b0); tick(1'b0);
    drive(0, 1'b1, 32'h22, 1'b0, 1'b0); tick(1'b0);
    check("pre_rst_occ", 32'(occupancy[0]), 32'd2);
    drive(0, 1'b1, 32'h23, 1'b1, 1'b0); tick(1'b1);
    idle_all();
    check("rst_occ", 32'(occupancy[0]), 32'd0);
    check("rst_cnt", stall_v[0], 32'd0);
    check("rst_rdy", 32'(in_ready[0]), 32'd1);
    tick(1'b0);

    // Randomized traffic with occasional flush, reset and long stalls.
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = int'($urandom_range(3, 12));
      for (int k = 0; k < 3; k++) begin
        drive(k, 1'($urandom_range(0, 1)), $urandom,
              (burst > 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 31) == 0));
      end
      if (burst > 0) burst--;
      tick(1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32, payload width in bits; legal range 1..256.
- SKID, 1, buffering mode: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_ON_FLUSH, 1, payload handling on flush: 1 = zero the payload registers; 0 = keep the payload and clear valid only.
- CNT_W, 16, width of the stall-cycle counter.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, discard all held entries.
- in_valid, in, 1, upstream offers data.
- in_ready, out, 1, stage accepts data.
- in_data, in, DATA_W, upstream payload.
- out_valid, out, 1, stage offers data.
- out_ready, in, 1, downstream accepts data.
- out_data, out, DATA_W, downstream payload.
- occupancy, out, 2, number of entries held (0..2).
- stall_cnt, out, CNT_W, saturating count of back-pressured cycles.

Function
REQ-004 An input transfer SHALL occur on a rising clk edge when in_valid=1 and in_ready=1.
REQ-005 An output transfer SHALL occur on a rising clk edge when out_valid=1 and out_ready=1.
REQ-006 Entries SHALL leave in the same order they were accepted, with no loss and no duplication.
REQ-007 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable until the transfer completes or a flush occurs.
REQ-008 With SKID=1, the state SHALL be one of EMPTY (occupancy 0), ONE (main entry only, occupancy 1) or FULL (main and skid entries, occupancy 2).
REQ-009 With SKID=1, in_ready SHALL equal (occupancy != 2) and SHALL be driven directly from a register, with no combinational path from out_ready.
REQ-010 With SKID=1, the transitions SHALL be:
- EMPTY to ONE on an input transfer.
- ONE to EMPTY on an output transfer with no input transfer.
- ONE stays ONE on simultaneous input and output transfers; main takes in_data.
- ONE to FULL on an input transfer with no output transfer; skid takes in_data.
- FULL to ONE on an output transfer; skid moves to main.
REQ-011 With SKID=0, the block SHALL hold one entry, and in_ready SHALL equal (out_ready | ~out_valid), combinationally.
REQ-012 With SKID=0, occupancy SHALL be 0 or 1 only.
REQ-013 out_valid SHALL equal (occupancy != 0).
REQ-014 Latency from an input transfer to out_valid=1 SHALL be one cycle when the stage was empty.
REQ-015 Sustained throughput SHALL be one transfer per cycle while out_ready=1, in both modes.
REQ-016 flush=1 SHALL, at the next edge, set occupancy to 0 and out_valid to 0, and discard any input transfer in that same cycle.
REQ-017 When flush=1 and CLEAR_ON_FLUSH=1, the payload registers SHALL be set to zero.
REQ-018 flush SHALL have priority over simultaneous input and output transfers.
REQ-019 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, and flush=0.
REQ-020 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 flush SHALL NOT clear stall_cnt.
REQ-022 The block SHALL NOT depend on in_data while in_valid=0, and out_data SHALL be zero whenever out_valid=0 and CLEAR_ON_FLUSH=1.

Reset
REQ-023 While reset=1 at a clk edge, occupancy, out_valid, out_data and stall_cnt SHALL be set to 0, and all other inputs SHALL be ignored.
REQ-024 After reset with SKID=1, in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-025 Reset asserted mid-operation, including in state FULL, SHALL discard all entries with no output transfer in the reset cycle.
REQ-026 reset SHALL have priority over flush.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- SKID=1, out_ready=1, stream 0x11..0x18 on consecutive cycles -> out_data 0x11..0x18 on consecutive cycles, first one cycle after acceptance; stall_cnt stays 0.
- SKID=1, out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy 2, in_ready=0, 0xC held upstream; then out_ready=1 -> outputs 0xA, 0xB, 0xC in order.
- SKID=1, FULL, flush=1 with in_valid=1 (0xD) and out_ready=1 -> no output transfer; next cycle occupancy 0, out_valid 0, out_data 0; 0xD lost.
- SKID=0, out_valid=1 (0x5), out_ready toggles 0,1,0,1 with in_valid=1 -> in_ready follows out_ready in the same cycle; no data lost or duplicated.
- CNT_W=2, hold out_valid=1 and out_ready=0 for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
- Reset pulsed for 1 cycle while FULL -> occupancy 0 and stall_cnt 0 the next cycle; in_ready=1.
